// File: rtl/seq_multiplier.sv
// seq_multiplier -- unsigned shift-and-add multiplier, one partial product per cycle.
//
// Ports
//   clk    : single clock, all state changes on the rising edge
//   rst    : synchronous active-high reset, wins over start
//   start  : begin a multiply; accepted only in IDLE or DONE
//   a, b   : multiplicand / multiplier, captured only on the accepting edge
//   busy   : high while the multiply is running (RUN)
//   done   : one-cycle pulse in the first cycle p shows a new result (DONE)
//   p      : 2*width-bit product, held between results
//
// Timing: start accepted at the edge ending cycle 0, busy in cycles 1..width,
// done and the new p in cycle width+1.

// One shift-and-add step: conditionally add the multiplicand into the upper
// half, then shift {carry, sum, lo} right by one.
module seq_multiplier_step #(
    parameter int width = 32
) (
    input  logic [width-1:0] mcand,
    input  logic [width-1:0] hi,
    input  logic [width-1:0] lo,
    output logic [width-1:0] hi_nxt,
    output logic [width-1:0] lo_nxt
);
    logic [width-1:0] addend;
    logic [width:0]   sum_c;   // {co, sum}

    always_comb begin
        addend = lo[0] ? mcand : '0;
        sum_c  = {1'b0, hi} + {1'b0, addend};
        // The carry-out lands in the MSB of hi; dropping it would corrupt
        // large products such as (2^width-1)^2.
        hi_nxt = sum_c[width:1];
        lo_nxt = {sum_c[0], lo[width-1:1]};
    end
endmodule

module seq_multiplier #(
    parameter int width = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [width-1:0]   a,
    input  logic [width-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*width-1:0] p
);
    localparam int CW = $clog2(width) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [width-1:0] mcand, hi, lo;
    logic [width-1:0] hi_step, lo_step;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last_step;

    seq_multiplier_step #(.width(width)) u_step (
        .mcand  (mcand),
        .hi     (hi),
        .lo     (lo),
        .hi_nxt (hi_step),
        .lo_nxt (lo_step)
    );

    // The step being performed this cycle is the width-th one.
    assign last_step = (cnt == CW'(width - 1));

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                accept = start;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                done   = 1'b1;
                accept = start;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            p     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mcand <= a;
                hi    <= '0;
                lo    <= b;
                cnt   <= '0;
            end else if (state == RUN) begin
                hi  <= hi_step;
                lo  <= lo_step;
                cnt <= cnt + 1'b1;
                // p only moves on entry to DONE, so it carries the previous
                // result through IDLE and the following RUN.
                if (last_step) p <= {hi_step, lo_step};
            end
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a, b;
    logic           busy, done;
    logic [2*W-1:0] p;

    int checks = 0;
    int errors = 0;

    seq_multiplier #(.width(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present operands with start in the current cycle (cycle 0), step to cycle 1.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
    endtask

    // From cycle 'first', advance until done, bounded. Returns the cycle index
    // at which done is seen and how many busy cycles preceded it.
    task automatic wait_done(input int first, output int lat, output int nbusy);
        lat   = first;
        nbusy = 0;
        while (!done && lat < 100) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, nbusy, npulse;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #1;

        // Reset, with start also high to show reset wins
        start = 1'b1; a = 32'd8; b = 32'd8;
        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_p",    p,         64'd0);

        // Basic 3*5, first start in the first cycle after reset release
        rst = 1'b0;
        launch(32'd3, 32'd5);
        check("basic_busy_c1", 64'(busy), 64'd1);
        check("basic_p_hold",  p,         64'd0);
        wait_done(1, lat, nbusy);
        check("basic_latency", 64'(lat),   64'd33);
        check("basic_nbusy",   64'(nbusy), 64'd32);
        check("basic_p",       p,          64'h0000_0000_0000_000F);
        tick();
        check("basic_done_pulse", 64'(done), 64'd0);
        check("basic_busy_idle",  64'(busy), 64'd0);
        check("basic_p_held",     p,         64'h0000_0000_0000_000F);

        // Max operands: carry-out retention
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("max_p_prior", p, 64'h0000_0000_0000_000F);
        wait_done(1, lat, nbusy);
        check("max_latency", 64'(lat), 64'd33);
        check("max_p",       p,        64'hFFFF_FFFE_0000_0001);
        tick();

        // Zero and identity
        launch(32'd0, 32'h1234_5678);
        wait_done(1, lat, nbusy);
        check("zero_p", p, 64'd0);
        tick();
        launch(32'h1234_5678, 32'd1);
        wait_done(1, lat, nbusy);
        check("ident_p", p, 64'h0000_0000_1234_5678);
        tick();

        // Start while busy is ignored; operand wiggle during RUN has no effect
        launch(32'd7, 32'd9);
        for (int c = 1; c < 10; c++) begin
            a = $urandom;
            b = $urandom;
            tick();
        end
        start = 1'b1; a = 32'd2; b = 32'd2;   // cycle 10
        tick();
        start = 1'b0;
        wait_done(11, lat, nbusy);
        check("busy_start_latency", 64'(lat), 64'd33);
        check("busy_start_p",       p,        64'd63);
        tick();

        // Back-to-back: start held through the DONE cycle
        launch(32'd5, 32'd5);
        wait_done(1, lat, nbusy);
        check("b2b_first_latency", 64'(lat), 64'd33);
        check("b2b_first_p",       p,        64'd25);
        start = 1'b1; a = 32'd4; b = 32'd6;
        tick();
        start = 1'b0;
        check("b2b_restart_busy", 64'(busy), 64'd1);
        check("b2b_restart_done", 64'(done), 64'd0);
        check("b2b_p_kept",       p,         64'd25);
        wait_done(1, lat, nbusy);
        check("b2b_second_latency", 64'(lat), 64'd33);
        check("b2b_second_p",       p,        64'd24);
        tick();

        // Reset mid-operation
        launch(32'd10, 32'd10);
        for (int c = 1; c < 15; c++) tick();
        rst = 1'b1;                            // cycle 15
        tick();
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_p",    p,         64'd0);
        npulse = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) npulse++;
            tick();
        end
        check("midrst_no_done", 64'(npulse), 64'd0);
        check("midrst_p_stays", p,           64'd0);

        // Recovery after the aborted run
        launch(32'd6, 32'd7);
        wait_done(1, lat, nbusy);
        check("recover_latency", 64'(lat), 64'd33);
        check("recover_p",       p,        64'd42);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
